// File: rtl/fetch_align.sv
// Fetch-side aligner: queues fetch words as 16-bit parcels and hands decode one
// RVC or 32-bit instruction per cycle, with its PC and access-fault flag.
`timescale 1ns/1ps
module fetch_align #(
    parameter int unsigned FETCH_WIDTH = 64,
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter bit          RVC_EN      = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [FETCH_WIDTH-1:0] fetch_data,
    input  logic                   fetch_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic                   out_rvc,
    output logic                   out_error
);

    localparam int unsigned FHW    = FETCH_WIDTH / 16;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SKIP_W = $clog2(FHW);
    localparam logic [SKIP_W-1:0] RESET_SKIP = RESET_PC[SKIP_W:1];

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } parcel_t;

    parcel_t           queue_q [DEPTH];
    parcel_t           queue_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       pc_q, pc_d;
    logic [SKIP_W-1:0] skip_q, skip_d;

    parcel_t           h0, h1;
    logic              head_rvc;
    logic [1:0]        consume;
    logic              push, pop;
    logic [CNT_W-1:0]  push_n;
    logic [PTR_W-1:0]  wr_idx;

    assign fetch_ready = !reset && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FHW));
    assign out_pc      = pc_q;

    // Instruction extraction from the two head parcels
    always_comb begin
        h0        = queue_q[rd_ptr_q];
        h1        = queue_q[rd_ptr_q + PTR_W'(1)];
        head_rvc  = RVC_EN && (h0.data[1:0] != 2'b11);
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_rvc   = 1'b0;
        out_error = 1'b0;
        consume   = 2'd0;
        if (h0.err) begin
            out_valid = (count_q >= CNT_W'(1));
            out_error = 1'b1;
            out_rvc   = 1'b1;
            consume   = 2'd1;
        end else if (head_rvc) begin
            out_valid = (count_q >= CNT_W'(1));
            out_instr = {16'h0, h0.data};
            out_rvc   = 1'b1;
            consume   = 2'd1;
        end else begin
            out_valid = (count_q >= CNT_W'(2));
            out_error = h1.err;
            out_instr = h1.err ? 32'h0 : {h1.data, h0.data};
            consume   = 2'd2;
        end
    end

    // Queue, pointer and PC update; flush overrides any same-cycle handshake
    always_comb begin
        push     = fetch_valid && fetch_ready && !flush;
        pop      = out_valid && out_ready && !flush;
        push_n   = push ? (CNT_W'(FHW) - CNT_W'(skip_q)) : '0;
        queue_d  = queue_q;
        wr_idx   = wr_ptr_q;
        if (push) begin
            for (int unsigned i = 0; i < FHW; i++) begin
                if (SKIP_W'(i) >= skip_q) begin
                    wr_idx = wr_ptr_q + PTR_W'(i) - PTR_W'(skip_q);
                    queue_d[wr_idx].err  = fetch_error;
                    queue_d[wr_idx].data = fetch_data[16*i +: 16];
                end
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(consume) : '0);
        count_d  = count_q + push_n - (pop ? CNT_W'(consume) : '0);
        pc_d     = pop ? (pc_q + 32'({consume, 1'b0})) : pc_q;
        skip_d   = push ? '0 : skip_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            pc_d     = flush_pc;
            skip_d   = flush_pc[SKIP_W:1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
            skip_q   <= RESET_SKIP;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            skip_q   <= skip_d;
        end
    end

    // Parcel storage needs no reset: count gates every read
    always_ff @(posedge clock) begin
        queue_q <= queue_d;
    end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: vector table for streaming, straddle, redirect,
// flush collision and faults, plus hand sequences for backpressure and reset.
`timescale 1ns/1ps
module tb_fetch_align;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_data;
    logic        fetch_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_rvc;
    logic        out_error;

    int checks = 0;
    int errors = 0;

    fetch_align #(
        .FETCH_WIDTH(64),
        .DEPTH(8),
        .RESET_PC(32'h0),
        .RVC_EN(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .flush_pc(flush_pc),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_data(fetch_data),
        .fetch_error(fetch_error),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_rvc(out_rvc),
        .out_error(out_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fv;
        logic [63:0] fd;
        logic        fe;
        logic        ordy;
        logic        fl;
        logic [31:0] fpc;
        logic        ov;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rvc;
        logic        err;
        logic        fr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [63:0] fd, input logic fe,
                       input logic ordy, input logic fl, input logic [31:0] fpc,
                       input logic ov, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rvc, input logic err, input logic fr);
        vec_t v;
        v.fv = fv; v.fd = fd; v.fe = fe; v.ordy = ordy; v.fl = fl; v.fpc = fpc;
        v.ov = ov; v.instr = instr; v.pc = pc; v.rvc = rvc; v.err = err; v.fr = fr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fv, input logic [63:0] fd, input logic fe,
                         input logic ordy, input logic fl, input logic [31:0] fpc);
        fetch_valid = fv;
        fetch_data  = fd;
        fetch_error = fe;
        out_ready   = ordy;
        flush       = fl;
        flush_pc    = fpc;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [31:0] instr,
                             input logic [31:0] pc, input logic rvc, input logic err);
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        if (ov) begin
            check({tag, " out_instr"}, out_instr, instr);
            check({tag, " out_pc"}, out_pc, pc);
            check({tag, " out_rvc"}, 32'(out_rvc), 32'(rvc));
            check({tag, " out_error"}, 32'(out_error), 32'(err));
        end
    endtask

    // Inputs change 1ns after posedge; outputs are sampled at negedge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.fv, v.fd, v.fe, v.ordy, v.fl, v.fpc);
        @(negedge clock);
        check({tag, " fetch_ready"}, 32'(fetch_ready), 32'(v.fr));
        check_out(tag, v.ov, v.instr, v.pc, v.rvc, v.err);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bp_exp [8];
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        @(negedge clock);
        check("reset fetch_ready", 32'(fetch_ready), 32'h0);
        step();
        reset = 1'b0;

        // fv  data                    fe ordy fl fpc         ov instr          pc           rvc err fr
        add(1, 64'h00200593_00100513, 0, 1, 0, 32'h0,      0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00100513, 32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00200593, 32'h4,       0, 0, 1);
        add(1, 64'h0513_4509_4505_4501, 0, 1, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004501, 32'h8,       1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004505, 32'hA,       1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004509, 32'hC,       1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      0, 32'h0,        32'h0,       0, 0, 1);
        add(1, 64'h0001_0001_4611_0010, 0, 1, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00100513, 32'hE,       0, 0, 0);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004611, 32'h12,      1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00000001, 32'h14,      1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00000001, 32'h16,      1, 0, 1);
        add(0, 64'h0,                 0, 1, 1, 32'h1006,   0, 32'h0,        32'h0,       0, 0, 1);
        add(1, 64'h4501_CCCC_BBBB_AAAA, 0, 1, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004501, 32'h1006,    1, 0, 1);
        add(1, 64'h0001_0001_0001_4501, 0, 0, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(1, 64'h1111_1111_1111_1111, 0, 1, 1, 32'h2000, 1, 32'h00004501, 32'h1008,    1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      0, 32'h0,        32'h0,       0, 0, 1);
        add(1, 64'h0001_0001_0001_4505, 0, 0, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00004505, 32'h2000,    1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00000001, 32'h2002,    1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00000001, 32'h2004,    1, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h00000001, 32'h2006,    1, 0, 1);
        add(1, 64'h0513_4509_4505_4501, 1, 0, 0, 32'h0,    0, 32'h0,        32'h0,       0, 0, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h0,        32'h2008,    1, 1, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h0,        32'h200A,    1, 1, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h0,        32'h200C,    1, 1, 1);
        add(0, 64'h0,                 0, 1, 0, 32'h0,      1, 32'h0,        32'h200E,    1, 1, 1);
        add(0, 64'h0,                 0, 0, 0, 32'h0,      0, 32'h0,        32'h0,       0, 0, 1);

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Backpressure: fill all 8 entries, hold, then drain in order
        bp_exp = '{16'h4501, 16'h4505, 16'h4509, 16'h450D,
                   16'h4511, 16'h4515, 16'h4519, 16'h451D};
        drive(1'b1, 64'h450D_4509_4505_4501, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check("bp0 fetch_ready", 32'(fetch_ready), 32'h1);
        check_out("bp0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h451D_4519_4515_4511, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check("bp1 fetch_ready", 32'(fetch_ready), 32'h1);
        check_out("bp1", 1'b1, 32'h4501, 32'h2010, 1'b1, 1'b0);
        step();
        drive(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check("bp2 fetch_ready", 32'(fetch_ready), 32'h0);
        check_out("bp2 hold", 1'b1, 32'h4501, 32'h2010, 1'b1, 1'b0);
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check("bp3 fetch_ready", 32'(fetch_ready), 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clock);
            check_out($sformatf("drain%0d", i), 1'b1, {16'h0, bp_exp[i]},
                      32'h2010 + 32'(2 * i), 1'b1, 1'b0);
            step();
        end
        @(negedge clock);
        check_out("drain empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("drain fetch_ready", 32'(fetch_ready), 32'h1);
        step();

        // Reset asserted mid-operation behaves like a flush to RESET_PC
        drive(1'b1, 64'h0001_0001_0001_4501, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check("midreset fetch_ready", 32'(fetch_ready), 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check_out("postreset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("postreset fetch_ready", 32'(fetch_ready), 32'h1);
        step();
        drive(1'b1, 64'h0001_0001_4611_4601, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check_out("postreset first", 1'b1, 32'h4601, 32'h0, 1'b1, 1'b0);
        step();
        @(negedge clock);
        check_out("postreset second", 1'b1, 32'h4611, 32'h2, 1'b1, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
